// File: rtl/os_sys_arr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : os_sys_arr_ctrl
// Brief    : Tile sequencer for an output-stationary systolic array. Applies
//            input skew and lane masks, sequences flow/drain, tags results.
// Options  : OS_CTRL_PERF_EN enables the perf_cycles / perf_bubbles counters.
// Revision : 1.0 - initial release
// ============================================================================
module os_sys_arr_ctrl #(
  parameter int ACT_WIDTH    = 8,
  parameter int WGT_WIDTH    = 8,
  parameter int PE_OUT_WIDTH = 32,
  parameter int SYS_ARR_SIZE = 8,
  parameter int K_W          = 16,
  parameter int PE_LAT       = 1,
  parameter int DRAIN_LAT    = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [$clog2(SYS_ARR_SIZE):0]        cfg_m,
  input  logic [$clog2(SYS_ARR_SIZE):0]        cfg_n,
  input  logic [K_W-1:0]                       cfg_k,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [ACT_WIDTH*SYS_ARR_SIZE-1:0]    in_act,
  input  logic [WGT_WIDTH*SYS_ARR_SIZE-1:0]    in_wgt,
  output logic                                 sys_reset,
  output logic [2:0]                           operation_signal,
  output logic [ACT_WIDTH*SYS_ARR_SIZE-1:0]    sys_act,
  output logic [WGT_WIDTH*SYS_ARR_SIZE-1:0]    sys_wgt,
  input  logic [PE_OUT_WIDTH*SYS_ARR_SIZE-1:0] sys_result,
  output logic                                 res_valid,
  output logic [$clog2(SYS_ARR_SIZE)-1:0]      res_row,
  output logic [PE_OUT_WIDTH*SYS_ARR_SIZE-1:0] res_data,
  output logic                                 busy,
  output logic                                 done,
  output logic [31:0]                          perf_cycles,
  output logic [31:0]                          perf_bubbles
);

  localparam int S         = SYS_ARR_SIZE;
  localparam int IW        = $clog2(S) + 1;
  localparam int RW        = $clog2(S);
  localparam int FLUSH_CYC = 2 * (S - 1) + PE_LAT;
  localparam int DRAIN_CYC = DRAIN_LAT + S;
  localparam int TW        = $clog2(FLUSH_CYC + DRAIN_CYC + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [IW-1:0]           r_m;
  logic [IW-1:0]           r_n;
  logic [K_W-1:0]          r_k;
  logic [K_W-1:0]          r_kcnt;
  logic [TW-1:0]           r_tcnt;
  logic                    w_accept;
  logic                    w_last_slice;
  logic                    w_dwin;
  logic                    w_cap;
  logic [RW-1:0]           w_drow;
  logic [PE_OUT_WIDTH*S-1:0] w_res_masked;
  logic                    r_res_valid;
  logic [RW-1:0]           r_res_row;
  logic [PE_OUT_WIDTH*S-1:0] r_res_data;

  assign w_accept     = (r_state == ST_FEED) && in_valid;
  assign w_last_slice = (r_kcnt == r_k - K_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next           = r_state;
    in_ready         = 1'b0;
    sys_reset        = 1'b0;
    operation_signal = 3'b100;
    busy             = 1'b1;
    done             = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        sys_reset = 1'b1;
        w_next    = (r_k == '0) ? ST_FLUSH : ST_FEED;
      end
      ST_FEED: begin
        in_ready = 1'b1;
        if (in_valid && w_last_slice) w_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (r_tcnt == TW'(FLUSH_CYC - 1)) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        operation_signal = 3'b110;
        if (r_tcnt == TW'(DRAIN_CYC - 1)) w_next = ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // r_tcnt restarts on every state change, so it is the cycle index within FLUSH/DRAIN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_m    <= '0;
      r_n    <= '0;
      r_k    <= '0;
      r_kcnt <= '0;
      r_tcnt <= '0;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_m <= cfg_m;
        r_n <= cfg_n;
        r_k <= cfg_k;
      end
      if (r_state == ST_CLEAR) r_kcnt <= '0;
      else if (w_accept)       r_kcnt <= r_kcnt + K_W'(1);
      r_tcnt <= (w_next != r_state) ? '0 : r_tcnt + TW'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < S; gi++) begin : g_lane
      logic [ACT_WIDTH-1:0] r_act_sk [0:gi];
      logic [WGT_WIDTH-1:0] r_wgt_sk [0:gi];
      logic                 w_act_en;
      logic                 w_wgt_en;

      // Bubbles, non-FEED cycles and masked lanes all inject zero
      assign w_act_en = w_accept && (IW'(gi) < r_m);
      assign w_wgt_en = w_accept && (IW'(gi) < r_n);

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int p = 0; p <= gi; p++) begin
            r_act_sk[p] <= '0;
            r_wgt_sk[p] <= '0;
          end
        end else begin
          r_act_sk[0] <= w_act_en ? in_act[gi*ACT_WIDTH +: ACT_WIDTH] : '0;
          r_wgt_sk[0] <= w_wgt_en ? in_wgt[gi*WGT_WIDTH +: WGT_WIDTH] : '0;
          for (int p = 1; p <= gi; p++) begin
            r_act_sk[p] <= r_act_sk[p-1];
            r_wgt_sk[p] <= r_wgt_sk[p-1];
          end
        end
      end

      assign sys_act[gi*ACT_WIDTH +: ACT_WIDTH] = r_act_sk[gi];
      assign sys_wgt[gi*WGT_WIDTH +: WGT_WIDTH] = r_wgt_sk[gi];
    end

    for (gi = 0; gi < S; gi++) begin : g_col
      assign w_res_masked[gi*PE_OUT_WIDTH +: PE_OUT_WIDTH] =
        (IW'(gi) < r_n) ? sys_result[gi*PE_OUT_WIDTH +: PE_OUT_WIDTH] : '0;
    end
  endgenerate

  // Drain cycle d presents row S-1-(d-DRAIN_LAT)
  assign w_dwin = (r_state == ST_DRAIN) && (r_tcnt >= TW'(DRAIN_LAT)) &&
                  (r_tcnt < TW'(DRAIN_CYC));
  assign w_drow = RW'(TW'(S - 1 + DRAIN_LAT) - r_tcnt);
  assign w_cap  = w_dwin && ({1'b0, w_drow} < r_m);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_res_valid <= 1'b0;
      r_res_row   <= '0;
      r_res_data  <= '0;
    end else begin
      r_res_valid <= w_cap;
      if (w_cap) begin
        r_res_row  <= w_drow;
        r_res_data <= w_res_masked;
      end
    end
  end

  assign res_valid = r_res_valid;
  assign res_row   = r_res_row;
  assign res_data  = r_res_data;

`ifdef OS_CTRL_PERF_EN
  logic [31:0] r_perf_cyc;
  logic [31:0] r_perf_bub;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_cyc <= '0;
      r_perf_bub <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_perf_cyc <= '0;
      r_perf_bub <= '0;
    end else begin
      if (r_state != ST_IDLE && r_perf_cyc != '1)
        r_perf_cyc <= r_perf_cyc + 32'd1;
      if (r_state == ST_FEED && !in_valid && r_perf_bub != '1)
        r_perf_bub <= r_perf_bub + 32'd1;
    end
  end

  assign perf_cycles  = r_perf_cyc;
  assign perf_bubbles = r_perf_bub;
`else
  assign perf_cycles  = '0;
  assign perf_bubbles = '0;
`endif

endmodule
`default_nettype wire
